conv_engine: RTL and testbench

- Sequential convolution core that produces the eight 8-bit results consumed by the 3-digit 7-segment display stage.
- Operands: one 4x4 image, one 3x3 kernel and one 2x2 kernel.
- c9_* outputs: 3x3 valid convolution, stride 1, giving a 2x2 result.
- c4_* outputs: 2x2 convolution, stride 2, giving a 2x2 result.
- One multiply-accumulate per clk_1hz edge, so each partial sum is observable during a demo.

---
 rtl/conv_if.sv | 23 ++
 rtl/conv_engine.sv | 134 +++++++++++++
 tb/tb_conv_engine.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/conv_if.sv
// Operand/result bundle between the display controller and conv_engine.
interface conv_if #(
  parameter int PIX_W = 4,
  parameter int OUT_W = 8
);
  logic                 start;
  logic [16*PIX_W-1:0]  img;
  logic [9*PIX_W-1:0]   k3;
  logic [4*PIX_W-1:0]   k2;
  logic                 busy;
  logic                 done;
  logic [OUT_W-1:0]     c9_11, c9_12, c9_21, c9_22;
  logic [OUT_W-1:0]     c4_11, c4_12, c4_21, c4_22;

  modport master (
    output start, img, k3, k2,
    input  busy, done, c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22
  );
  modport slave (
    input  start, img, k3, k2,
    output busy, done, c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22
  );
endinterface

// File: rtl/conv_engine.sv
// One-MAC-per-edge 3x3 (valid) and 2x2 stride-2 convolution over a latched 4x4 image.
// Optional macro CONV_SATURATE_EN: results saturate at 2^OUT_W-1 instead of wrapping.
module conv_engine #(
  parameter int PIX_W = 4,
  parameter int OUT_W = 8
) (
  input  logic clk_1hz,
  input  logic resetn,
  conv_if.slave bus
);
  localparam int ACC_W = 2*PIX_W + 4;
  localparam logic [1:0] IDLE = 2'd0, CONV9 = 2'd1, CONV4 = 2'd2, DONE = 2'd3;

  logic [1:0]              state;
  logic [1:0]              out_idx;
  logic [3:0]              tap;
  logic [ACC_W-1:0]        acc;
  logic [16*PIX_W-1:0]     img_q;
  logic [9*PIX_W-1:0]      k3_q;
  logic [4*PIX_W-1:0]      k2_q;
  logic [3:0][OUT_W-1:0]   c9_q, c4_q;
  logic                    busy_q, done_q;

  logic [1:0]              ti, tj;
  logic [2:0]              row, col;
  int unsigned             pidx, kidx;
  logic [PIX_W-1:0]        pix, kt;
  logic [ACC_W-1:0]        sum;
  logic [OUT_W-1:0]        red;

  // Tap number -> kernel (i,j); the window origin depends on which pass is running.
  always_comb begin
    ti = 2'd0;
    tj = 2'd0;
    if (state == CONV4) begin
      ti  = {1'b0, tap[1]};
      tj  = {1'b0, tap[0]};
      row = {1'b0, out_idx[1], 1'b0} + {1'b0, ti};
      col = {1'b0, out_idx[0], 1'b0} + {1'b0, tj};
    end else begin
      case (tap)
        4'd1: begin ti = 2'd0; tj = 2'd1; end
        4'd2: begin ti = 2'd0; tj = 2'd2; end
        4'd3: begin ti = 2'd1; tj = 2'd0; end
        4'd4: begin ti = 2'd1; tj = 2'd1; end
        4'd5: begin ti = 2'd1; tj = 2'd2; end
        4'd6: begin ti = 2'd2; tj = 2'd0; end
        4'd7: begin ti = 2'd2; tj = 2'd1; end
        4'd8: begin ti = 2'd2; tj = 2'd2; end
        default: begin ti = 2'd0; tj = 2'd0; end
      endcase
      row = {2'b0, out_idx[1]} + {1'b0, ti};
      col = {2'b0, out_idx[0]} + {1'b0, tj};
    end
    pidx = 32'(row[1:0]) * 4 + 32'(col[1:0]);
    kidx = (state == CONV4) ? 32'(tap[1:0]) : ((tap > 4'd8) ? 32'd0 : 32'(tap));
    pix  = img_q[pidx*PIX_W +: PIX_W];
    kt   = (state == CONV4) ? k2_q[kidx*PIX_W +: PIX_W] : k3_q[kidx*PIX_W +: PIX_W];
    sum  = acc + ACC_W'(pix) * ACC_W'(kt);
`ifdef CONV_SATURATE_EN
    red  = (sum > ACC_W'((1 << OUT_W) - 1)) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
    red  = sum[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk_1hz or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      out_idx <= '0;
      tap     <= '0;
      acc     <= '0;
      img_q   <= '0;
      k3_q    <= '0;
      k2_q    <= '0;
      c9_q    <= '0;
      c4_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          img_q   <= bus.img;
          k3_q    <= bus.k3;
          k2_q    <= bus.k2;
          c9_q    <= '0;
          c4_q    <= '0;
          acc     <= '0;
          out_idx <= '0;
          tap     <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state   <= CONV9;
        end
        CONV9: if (tap == 4'd8) begin
          c9_q[out_idx] <= red;
          acc           <= '0;
          tap           <= '0;
          out_idx       <= out_idx + 2'd1;
          if (out_idx == 2'd3) state <= CONV4;
        end else begin
          acc <= sum;
          tap <= tap + 4'd1;
        end
        CONV4: if (tap == 4'd3) begin
          c4_q[out_idx] <= red;
          acc           <= '0;
          tap           <= '0;
          out_idx       <= out_idx + 2'd1;
          if (out_idx == 2'd3) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else begin
          acc <= sum;
          tap <= tap + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.c9_11 = c9_q[0];
  assign bus.c9_12 = c9_q[1];
  assign bus.c9_21 = c9_q[2];
  assign bus.c9_22 = c9_q[3];
  assign bus.c4_11 = c4_q[0];
  assign bus.c4_12 = c4_q[1];
  assign bus.c4_21 = c4_q[2];
  assign bus.c4_22 = c4_q[3];
endmodule

// File: tb/tb_conv_engine.sv
// Randomized and directed checks of conv_engine against a loop-based convolution model.
module tb_conv_engine;
  localparam int PW = 4;
  localparam int OW = 8;

  logic clk_1hz;
  logic resetn;
  conv_if #(.PIX_W(PW), .OUT_W(OW)) bus ();

  conv_engine #(.PIX_W(PW), .OUT_W(OW)) dut (
    .clk_1hz (clk_1hz),
    .resetn  (resetn),
    .bus     (bus)
  );

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  int n_tests = 0;
  int n_fail  = 0;
  int exp9[4];
  int exp4[4];
  logic [OW-1:0] o9[4];
  logic [OW-1:0] o4[4];

  assign o9[0] = bus.c9_11; assign o9[1] = bus.c9_12;
  assign o9[2] = bus.c9_21; assign o9[3] = bus.c9_22;
  assign o4[0] = bus.c4_11; assign o4[1] = bus.c4_12;
  assign o4[2] = bus.c4_21; assign o4[3] = bus.c4_22;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int reduce(input int x);
`ifdef CONV_SATURATE_EN
    return (x > 255) ? 255 : x;
`else
    return x % 256;
`endif
  endfunction

  task automatic model(input logic [63:0] im, input logic [35:0] a, input logic [15:0] b);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int s9, s4;
        s9 = 0;
        s4 = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s9 += int'(im[((r+i)*4 + c+j)*PW +: PW]) * int'(a[(i*3+j)*PW +: PW]);
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            s4 += int'(im[((2*r+i)*4 + 2*c+j)*PW +: PW]) * int'(b[(i*2+j)*PW +: PW]);
        exp9[r*2+c] = reduce(s9);
        exp4[r*2+c] = reduce(s4);
      end
  endtask

  task automatic step();
    @(posedge clk_1hz);
    #1;
  endtask

  // e = edges since the start edge; each result appears only after its own write edge.
  task automatic check_edge(input int e);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("e%0d c9[%0d]", e, k), 32'(o9[k]), (e >= 9*(k+1)) ? exp9[k] : 0);
      chk($sformatf("e%0d c4[%0d]", e, k), 32'(o4[k]), (e >= 36 + 4*(k+1)) ? exp4[k] : 0);
    end
    chk($sformatf("e%0d busy", e), 32'(bus.busy), (e < 52) ? 1 : 0);
    chk($sformatf("e%0d done", e), 32'(bus.done), (e >= 52) ? 1 : 0);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s c9[%0d]", tag, k), 32'(o9[k]), 0);
      chk($sformatf("%s c4[%0d]", tag, k), 32'(o4[k]), 0);
    end
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
  endtask

  // mode 0: plain run; 1: img change + start pulse at edge 20; 2: start held -> retrigger
  task automatic run(input logic [63:0] im, input logic [35:0] a, input logic [15:0] b, input int mode);
    model(im, a, b);
    bus.img = im; bus.k3 = a; bus.k2 = b;
    bus.start = 1'b1;
    step();
    check_edge(0);
    bus.start = (mode == 2);
    for (int e = 1; e <= 52; e++) begin
      if (mode == 1 && e == 20) begin
        bus.img = ~im;
        bus.start = 1'b1;
      end
      step();
      if (mode == 1 && e == 20) bus.start = 1'b0;
      check_edge(e);
    end
    if (mode == 2) begin
      step();
      bus.start = 1'b0;
      check_edge(0);
      for (int e = 1; e <= 52; e++) begin
        step();
        check_edge(e);
      end
    end
  endtask

  initial begin
    logic [63:0] t64;
    logic [63:0] ramp;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.img = '0; bus.k3 = '0; bus.k2 = '0;
    step();
    step();
    check_zero("rst");
    resetn = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      check_zero($sformatf("idle%0d", e));
    end

    run({16{4'd1}}, {9{4'd1}}, {4{4'd1}}, 0);

    for (int p = 0; p < 16; p++) ramp[p*PW +: PW] = 4'(p);
    run(ramp, 36'h0_0001_0000, 16'h0001, 0);

    run({16{4'hF}}, {9{4'hF}}, {4{4'hF}}, 0);

    for (int n = 0; n < 5; n++) begin
      t64 = {$urandom(), $urandom()};
      ramp = {$urandom(), $urandom()};
      run(t64, ramp[35:0], ramp[63:48], 0);
    end

    t64 = {$urandom(), $urandom()};
    run(t64, {9{4'h7}}, 16'hA5C3, 1);

    t64 = {$urandom(), $urandom()};
    run(t64, 36'h9_8765_4321, 16'h4321, 2);

    // reset in the middle of a run
    t64 = {$urandom(), $urandom()};
    model(t64, 36'hF_FFFF_FFFF, 16'hFFFF);
    bus.img = t64; bus.k3 = 36'hF_FFFF_FFFF; bus.k2 = 16'hFFFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      check_edge(e);
    end
    resetn = 1'b0;
    #1;
    check_zero("midrst");
    step();
    check_zero("midrst_hold");
    resetn = 1'b1;
    step();
    check_zero("postrst");
    ramp = {$urandom(), $urandom()};
    run(t64, ramp[35:0], ramp[15:0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
